stream_alu: RTL and testbench
=============================

# stream_alu

Parametrised, handshaked successor to the single-opcode DUT datapath: a signed integer ALU over a stream of operand pairs, supporting elementwise binary ops and whole-packet column reductions (sum, count, max) delimited by a last flag. It sits between the column DMA reader and the result writer in the pandas offload fabric. Valid/ready on both sides gives one result per cycle with back-pressure.

## Interface
- NUM_SIZE, 16: operand/result width, signed two's complement
- CMD_SIZE_LOG2, 2: cmd port is 2**CMD_SIZE_LOG2 bits wide
- ACC_EXTRA, 8: guard bits on the reduction accumulator (width NUM_SIZE+ACC_EXTRA)
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- enable  in  1  block enable; low = synchronous clear to reset state, in_ready forced 0
- in_valid  in  1  operand beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_last  in  1  final beat of a packet (meaningful for reductions)
- in1, in2  in  NUM_SIZE  signed operands (in2 ignored by reductions)
- cmd  in  2**CMD_SIZE_LOG2  opcode, sampled on a packet's first accepted beat
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  downstream accepts result
- out_last  out  1  result is last of its packet
- out  out  NUM_SIZE  signed result
- ovf  out  1  result overflowed NUM_SIZE (qualified by out_valid)

## Operation
- Opcodes: NOOP=0, ADD=1, SUB=2 (in1-in2), MIN=3, MAX=4 (signed), SUM=5, CNT=6, RMAX=7; all others treated as NOOP.
- NOOP/unknown: beat consumed, no result produced; an in_last on such a beat is dropped.
- Elementwise (ADD..MAX): one result per accepted beat; out_last = in_last of that beat.
- Reductions (SUM/CNT/RMAX): accumulate across beats; single result with out_last=1 after the in_last beat. CNT counts accepted beats including the last; RMAX starts from the first beat's in1.
- FSM: IDLE -> ACC on an accepted reduction beat without in_last; IDLE/ACC -> EMIT on an accepted reduction beat with in_last; EMIT -> IDLE when out_valid && out_ready. Elementwise beats stay in IDLE.
- Opcode latched on a packet's first beat; cmd changes during ACC are ignored until the packet ends.
- Arithmetic: elementwise in NUM_SIZE+1 bits; the accumulator is NUM_SIZE+ACC_EXTRA bits and wraps internally. On output, a value outside the NUM_SIZE signed range sets ovf=1 and is truncated (wrap); in-range gives ovf=0. MIN/MAX/RMAX never overflow.
- in_ready: IDLE/ACC elementwise path = !out_valid || out_ready; in ACC, 1 (no output pending); in EMIT, 0.
- Reset or enable=0 mid-packet: accumulator discarded, FSM to IDLE, pending result dropped.

## Timing
- Reset values: out=0, out_valid=0, out_last=0, ovf=0, in_ready=0 while reset asserted, FSM=IDLE, accumulator=0.
- in_ready rises the first clk edge after reset deasserts with enable=1.
- Elementwise latency 1 cycle: beat accepted at edge N gives out_valid at N+1; full throughput with out_ready=1.
- Reduction: result valid 1 cycle after the in_last beat; one bubble cycle (EMIT) before the next packet's beat can be accepted.
- Stall: out, out_last and ovf stable while out_valid && !out_ready.
- Simultaneous result consume and new beat accept in the same cycle is legal on the elementwise path.

## Configuration
- STREAM_ALU_SATURATE_EN defined: overflowing results clamp to the max positive or min negative NUM_SIZE value, ovf still set. CNT clamps at max positive.
- Undefined: wrap-around truncation as above.

## Structure
- Shared package stream_alu_pkg: opcode enum (values above), FSM state enum, NUM_SIZE/CMD_SIZE_LOG2 defaults; shared with the driver-side definitions header.
- One sub-module stream_alu_op: combinational elementwise op plus range check and wrap/saturate stage, reused for the reduction output narrowing.

## Test plan
- ADD 100+(-30), out_ready=1 -> out=70, ovf=0, out_valid at the next cycle; 8 back-to-back beats -> 8 consecutive results, no bubbles.
- ADD 16'sh7FFF+1 -> wrap build out=16'sh8000, ovf=1; STREAM_ALU_SATURATE_EN build out=16'sh7FFF, ovf=1.
- SUM packet {5,-2,10} with in_last on 10 -> single out=13, out_last=1, ovf=0; CNT of the same packet -> 3; RMAX -> 10.
- Back-pressure: out_ready=0 for 4 cycles during an elementwise stream -> in_ready=0 after one pending result, out held stable, no beat lost or duplicated.
- cmd changed SUM->ADD mid-packet -> ignored until in_last; then the next packet runs ADD; opcode 9 beat -> consumed, no output.
- reset pulsed low mid-SUM packet -> all outputs 0 immediately; the next packet SUM {1,1} -> 2 (no stale accumulation); enable=0 gives the same clearing.

Source files
------------

// File: rtl/stream_alu_pkg.sv
// Shared opcode/state types and parameter defaults for stream_alu.
// The driver-side definitions header mirrors these opcode values.
package stream_alu_pkg;

    localparam int NUM_SIZE_DEF      = 16;
    localparam int CMD_SIZE_LOG2_DEF = 2;
    localparam int ACC_EXTRA_DEF     = 8;

    typedef enum logic [2:0] {
        OP_NOOP = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MIN  = 3'd3,
        OP_MAX  = 3'd4,
        OP_SUM  = 3'd5,
        OP_CNT  = 3'd6,
        OP_RMAX = 3'd7
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_EMIT
    } state_t;

    function automatic logic is_reduction(input op_t op);
        return (op == OP_SUM) || (op == OP_CNT) || (op == OP_RMAX);
    endfunction

endpackage

// File: rtl/stream_alu_op.sv
// Combinational elementwise op, then range check and narrowing to NUM_SIZE.
// Define STREAM_ALU_SATURATE_EN to clamp out-of-range results instead of wrapping.
module stream_alu_op
    import stream_alu_pkg::*;
#(
    parameter int NUM_SIZE = NUM_SIZE_DEF,
    parameter int ACC_W    = NUM_SIZE_DEF + ACC_EXTRA_DEF
) (
    input  op_t                       op,
    input  logic signed [NUM_SIZE-1:0] in1,
    input  logic signed [NUM_SIZE-1:0] in2,
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [NUM_SIZE-1:0] res,
    output logic                       ovf
);

`ifdef STREAM_ALU_SATURATE_EN
    localparam logic [NUM_SIZE-1:0] MAX_POS = {1'b0, {(NUM_SIZE-1){1'b1}}};
    localparam logic [NUM_SIZE-1:0] MIN_NEG = {1'b1, {(NUM_SIZE-1){1'b0}}};
`endif

    logic signed [NUM_SIZE:0]   a_x;
    logic signed [NUM_SIZE:0]   b_x;
    logic signed [NUM_SIZE:0]   elem;
    logic signed [ACC_W-1:0]    wide;
    logic [ACC_W-NUM_SIZE:0]    top_bits;
    logic                       in_range;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        a_x  = {in1[NUM_SIZE-1], in1};
        b_x  = {in2[NUM_SIZE-1], in2};
        elem = '0;
        case (op)
            OP_ADD:  elem = a_x + b_x;
            OP_SUB:  elem = a_x - b_x;
            OP_MIN:  elem = (a_x < b_x) ? a_x : b_x;
            OP_MAX:  elem = (a_x > b_x) ? a_x : b_x;
            default: elem = '0;
        endcase

        // Reductions narrow the accumulator; elementwise ops narrow their own result.
        wide     = is_reduction(op) ? acc : ACC_W'(elem);
        top_bits = wide[ACC_W-1:NUM_SIZE-1];
        in_range = (&top_bits) || !(|top_bits);
        ovf      = !in_range;
`ifdef STREAM_ALU_SATURATE_EN
        res = in_range ? wide[NUM_SIZE-1:0] : (wide[ACC_W-1] ? MIN_NEG : MAX_POS);
`else
        res = wide[NUM_SIZE-1:0];
`endif
    end

endmodule

// File: rtl/stream_alu.sv
// Handshaked signed ALU: elementwise ops per beat, SUM/CNT/RMAX reductions per packet.
// Define STREAM_ALU_SATURATE_EN for saturating output narrowing (default wraps).
module stream_alu
    import stream_alu_pkg::*;
#(
    parameter int NUM_SIZE      = NUM_SIZE_DEF,
    parameter int CMD_SIZE_LOG2 = CMD_SIZE_LOG2_DEF,
    parameter int ACC_EXTRA     = ACC_EXTRA_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic signed [NUM_SIZE-1:0]      in1,
    input  logic signed [NUM_SIZE-1:0]      in2,
    input  logic [2**CMD_SIZE_LOG2-1:0]     cmd,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic signed [NUM_SIZE-1:0]      out,
    output logic                            ovf
);

    localparam int CMD_W = 2**CMD_SIZE_LOG2;
    localparam int ACC_W = NUM_SIZE + ACC_EXTRA;

    function automatic op_t decode(input logic [CMD_W-1:0] c);
        logic [31:0] cv;
        cv = 32'(c);
        return (cv < 32'd8) ? op_t'(cv[2:0]) : OP_NOOP;
    endfunction

    state_t                     state;
    op_t                        acc_op;
    op_t                        cmd_op;
    op_t                        eff_op;
    logic                       run;
    logic                       first;
    logic                       accept;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    in1_x;
    logic signed [NUM_SIZE-1:0] res;
    logic                       res_ovf;

    // The opcode is taken from cmd only on a packet's first beat.
    assign cmd_op   = decode(cmd);
    assign eff_op   = (state == ST_ACC) ? acc_op : cmd_op;
    assign first    = (state == ST_IDLE);
    assign in_ready = run && enable &&
                      ((state == ST_ACC) || (first && (!out_valid || out_ready)));
    assign accept   = in_valid && in_ready;
    assign in1_x    = ACC_W'(in1);

    always_comb begin
        acc_next = acc;
        case (eff_op)
            OP_SUM:  acc_next = (first ? '0 : acc) + in1_x;
            OP_CNT:  acc_next = (first ? '0 : acc) + ACC_W'(1);
            OP_RMAX: acc_next = (first || (in1_x > acc)) ? in1_x : acc;
            default: acc_next = acc;
        endcase
    end

    stream_alu_op #(
        .NUM_SIZE (NUM_SIZE),
        .ACC_W    (ACC_W)
    ) u_op (
        .op  (eff_op),
        .in1 (in1),
        .in2 (in2),
        .acc (acc_next),
        .res (res),
        .ovf (res_ovf)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            acc_op    <= OP_NOOP;
            acc       <= '0;
            run       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
        end else if (!enable) begin
            state     <= ST_IDLE;
            acc_op    <= OP_NOOP;
            acc       <= '0;
            run       <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out       <= '0;
            ovf       <= 1'b0;
        end else begin
            run <= 1'b1;
            // Data fields are left untouched on consume so they only change with a new result.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_ACC: begin
                    if (accept && is_reduction(eff_op)) begin
                        if (first) begin
                            acc_op <= eff_op;
                        end
                        if (in_last) begin
                            acc       <= '0;
                            out       <= res;
                            ovf       <= res_ovf;
                            out_last  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= ST_EMIT;
                        end else begin
                            acc   <= acc_next;
                            state <= ST_ACC;
                        end
                    end else if (accept && (eff_op != OP_NOOP)) begin
                        out       <= res;
                        ovf       <= res_ovf;
                        out_last  <= in_last;
                        out_valid <= 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (out_valid && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_alu.sv
// Directed self-checking bench for stream_alu; expected values computed by hand.
`timescale 1ns/1ps
module tb_stream_alu;

    localparam logic [3:0] C_NOOP = 4'd0;
    localparam logic [3:0] C_ADD  = 4'd1;
    localparam logic [3:0] C_SUB  = 4'd2;
    localparam logic [3:0] C_MIN  = 4'd3;
    localparam logic [3:0] C_MAX  = 4'd4;
    localparam logic [3:0] C_SUM  = 4'd5;
    localparam logic [3:0] C_CNT  = 4'd6;
    localparam logic [3:0] C_RMAX = 4'd7;
    localparam logic [3:0] C_BAD  = 4'd9;

`ifdef STREAM_ALU_SATURATE_EN
    localparam logic [15:0] ADD_OVF_EXP = 16'h7FFF;
    localparam logic [15:0] SUB_OVF_EXP = 16'h8000;
    localparam logic [15:0] SUM_OVF_EXP = 16'h7FFF;
`else
    localparam logic [15:0] ADD_OVF_EXP = 16'h8000;
    localparam logic [15:0] SUB_OVF_EXP = 16'h7FFF;
    localparam logic [15:0] SUM_OVF_EXP = 16'h8000;
`endif

    logic               clk;
    logic               reset;
    logic               enable;
    logic               in_valid;
    logic               in_ready;
    logic               in_last;
    logic signed [15:0] in1;
    logic signed [15:0] in2;
    logic [3:0]         cmd;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic signed [15:0] out;
    logic               ovf;

    int total;
    int bad;

    stream_alu dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in1       (in1),
        .in2       (in2),
        .cmd       (cmd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out       (out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for in_ready, let it be accepted, then drop in_valid.
    task automatic beat(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                        input logic last);
        int n;
        cmd      = c;
        in1      = a;
        in2      = b;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 10) begin
            step();
            n++;
        end
        check("beat_ready", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in1       = '0;
        in2       = '0;
        cmd       = '0;
        out_ready = 1'b1;

        repeat (3) step();
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out", out, 16'h0000);
        check("rst_out_last", out_last, 1'b0);
        check("rst_ovf", ovf, 1'b0);

        reset = 1'b1;
        #1;
        check("ready_before_edge", in_ready, 1'b0);
        step();
        check("ready_after_edge", in_ready, 1'b1);

        // ADD 100 + (-30), result one cycle after acceptance
        beat(C_ADD, 16'd100, 16'hFFE2, 1'b0);
        check("add_valid", out_valid, 1'b1);
        check("add_out", out, 16'd70);
        check("add_ovf", ovf, 1'b0);

        // 8 back-to-back beats: a new result every cycle
        for (int i = 0; i < 8; i++) begin
            beat(C_ADD, 16'(10 * i), 16'(i), (i == 7));
            check("b2b_valid", out_valid, 1'b1);
            check("b2b_out", out, 16'(11 * i));
            check("b2b_last", out_last, (i == 7));
        end
        step();
        check("b2b_drained", out_valid, 1'b0);

        beat(C_ADD, 16'h7FFF, 16'h0001, 1'b0);
        check("add_ovf_out", out, ADD_OVF_EXP);
        check("add_ovf_flag", ovf, 1'b1);
        beat(C_SUB, 16'h8000, 16'h0001, 1'b0);
        check("sub_ovf_out", out, SUB_OVF_EXP);
        check("sub_ovf_flag", ovf, 1'b1);
        beat(C_SUB, 16'd5, 16'd8, 1'b0);
        check("sub_out", out, 16'hFFFD);
        check("sub_ovf", ovf, 1'b0);
        beat(C_MIN, 16'hFFFB, 16'd3, 1'b0);
        check("min_out", out, 16'hFFFB);
        beat(C_MAX, 16'hFFFB, 16'd3, 1'b0);
        check("max_out", out, 16'd3);

        // SUM {5,-2,10}
        beat(C_SUM, 16'd5, 16'd0, 1'b0);
        check("sum_acc1_valid", out_valid, 1'b0);
        beat(C_SUM, 16'hFFFE, 16'd0, 1'b0);
        check("sum_acc2_valid", out_valid, 1'b0);
        beat(C_SUM, 16'd10, 16'd0, 1'b1);
        check("sum_valid", out_valid, 1'b1);
        check("sum_out", out, 16'd13);
        check("sum_last", out_last, 1'b1);
        check("sum_ovf", ovf, 1'b0);

        // The EMIT cycle blocks the next packet's first beat
        cmd      = C_CNT;
        in1      = 16'd5;
        in_valid = 1'b1;
        #1;
        check("emit_bubble", in_ready, 1'b0);

        beat(C_CNT, 16'd5, 16'd0, 1'b0);
        check("cnt_acc_valid", out_valid, 1'b0);
        beat(C_CNT, 16'hFFFE, 16'd0, 1'b0);
        beat(C_CNT, 16'd10, 16'd0, 1'b1);
        check("cnt_out", out, 16'd3);
        check("cnt_last", out_last, 1'b1);

        beat(C_RMAX, 16'd5, 16'd0, 1'b0);
        beat(C_RMAX, 16'hFFFE, 16'd0, 1'b0);
        beat(C_RMAX, 16'd10, 16'd0, 1'b1);
        check("rmax_out", out, 16'd10);
        check("rmax_ovf", ovf, 1'b0);

        beat(C_RMAX, 16'hFFF0, 16'd0, 1'b1);
        check("rmax_single_out", out, 16'hFFF0);
        check("rmax_single_valid", out_valid, 1'b1);
        step();
        check("drain_valid", out_valid, 1'b0);

        // Back-pressure: one pending result, held for 4 cycles, then resumes
        out_ready = 1'b0;
        beat(C_ADD, 16'd1, 16'd1, 1'b0);
        check("bp_first", out, 16'd2);
        cmd      = C_ADD;
        in1      = 16'd2;
        in2      = 16'd2;
        in_last  = 1'b1;
        in_valid = 1'b1;
        #1;
        check("bp_ready_low", in_ready, 1'b0);
        repeat (4) begin
            step();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_out", out, 16'd2);
            check("bp_hold_last", out_last, 1'b0);
            check("bp_hold_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_back", in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        check("bp_second_out", out, 16'd4);
        check("bp_second_last", out_last, 1'b1);
        check("bp_second_valid", out_valid, 1'b1);
        step();
        check("bp_no_dup", out_valid, 1'b0);

        // SUM overflow at narrowing
        beat(C_SUM, 16'h7FFF, 16'd0, 1'b0);
        beat(C_SUM, 16'd1, 16'd0, 1'b1);
        check("sum_ovf_out", out, SUM_OVF_EXP);
        check("sum_ovf_flag", ovf, 1'b1);

        // cmd changed to ADD mid-SUM packet is ignored until in_last
        beat(C_SUM, 16'd3, 16'd0, 1'b0);
        beat(C_ADD, 16'd4, 16'd100, 1'b0);
        check("cmdchg_no_out", out_valid, 1'b0);
        beat(C_ADD, 16'd5, 16'd0, 1'b1);
        check("cmdchg_sum", out, 16'd12);
        check("cmdchg_last", out_last, 1'b1);
        beat(C_ADD, 16'd2, 16'd3, 1'b0);
        check("next_add_out", out, 16'd5);
        check("next_add_last", out_last, 1'b0);

        beat(C_BAD, 16'd1, 16'd1, 1'b1);
        check("op9_no_out", out_valid, 1'b0);
        beat(C_NOOP, 16'd1, 16'd1, 1'b0);
        check("noop_no_out", out_valid, 1'b0);

        // Reset mid-SUM packet
        beat(C_SUM, 16'd50, 16'd0, 1'b0);
        beat(C_SUM, 16'd50, 16'd0, 1'b0);
        reset = 1'b0;
        #1;
        check("midrst_out", out, 16'h0000);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_ready", in_ready, 1'b0);
        reset = 1'b1;
        step();
        beat(C_SUM, 16'd1, 16'd0, 1'b0);
        beat(C_SUM, 16'd1, 16'd0, 1'b1);
        check("post_rst_sum", out, 16'd2);

        // enable=0 mid-SUM packet
        beat(C_SUM, 16'd50, 16'd0, 1'b0);
        enable = 1'b0;
        #1;
        check("en0_ready", in_ready, 1'b0);
        step();
        check("en0_out", out, 16'h0000);
        check("en0_valid", out_valid, 1'b0);
        enable = 1'b1;
        step();
        beat(C_SUM, 16'd1, 16'd0, 1'b0);
        beat(C_SUM, 16'd1, 16'd0, 1'b1);
        check("post_en_sum", out, 16'd2);
        check("post_en_last", out_last, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
